pmu_cfg_arb: RTL
================

// Module: pmu_cfg_arb
// PURPOSE
//  Shares the single AD5522 SPI config path (pmu_drv wr/rd request interface) among NUM_REQ requesters
//  (e.g. PS register bank, power-up init sequencer, calibration engine). Round-robin grants one transaction
//  at a time, holds off while AD5522 reset is busy, times out hung SPI transfers, and returns read data
//  and status to the granted requester.
// PARAMETERS
//  NUM_REQ     2    number of requesters (1..8)
//  PMU_CFG_DW  29   AD5522 SPI word width
//  TMO_CYC     4096 clk cycles allowed from issue to wr_done/rd_done before timeout
// PORTS
//  clk            in   1               system clock, 100 MHz
//  rst            in   1               synchronous, active-high reset
//  req_vld        in   NUM_REQ         per-requester request, level, held until req_ack
//  req_rd         in   NUM_REQ         1 = read(compare reg), 0 = write
//  req_data       in   NUM_REQ*DW      write word; requester i at [i*DW +: DW]
//  req_ack        out  NUM_REQ         1-cycle completion pulse to granted requester
//  rsp_data       out  DW              read result (valid with req_ack on a read)
//  rsp_err        out  1               timeout (or readback mismatch), valid with req_ack
//  busy           out  1               transaction in flight
//  pmu_cfg_wr_req out  1               1-cycle pulse to pmu_drv
//  pmu_cfg_rd_req out  1               1-cycle pulse to pmu_drv
//  pmu_cfg_wr_data out DW              word to pmu_drv, stable from issue to done
//  pmu_cfg_wr_done in  1               pulse from pmu_drv
//  pmu_cfg_rd_done in  1               pulse from pmu_drv
//  pmu_cmp_result  in  DW              read data from pmu_drv
//  pmu_cmp_result_vld in 1             read data strobe
//  ad5522_rst_busy in  1               1 = AD5522 in reset/calibration; no SPI traffic allowed
//  tmo_cnt        out  16              saturating count of timeouts since rst
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, round-robin pointer=0, tmo_cnt=0.
//  - FSM: IDLE -> (any req_vld && !ad5522_rst_busy) ARB -> ISSUE -> WAIT -> RESP -> IDLE.
//  - ARB: pick first set req_vld at or after rr_ptr (wrapping); latch id, rd flag, data. 1 cycle.
//  - ISSUE: pulse pmu_cfg_wr_req or pmu_cfg_rd_req exactly 1 cycle; clear timeout counter.
//  - WAIT: write ends on pmu_cfg_wr_done; read ends on pmu_cfg_rd_done, rsp_data latched from
//    pmu_cmp_result on pmu_cmp_result_vld (vld may precede or coincide with rd_done).
//    Timeout counter reaching TMO_CYC-1 -> RESP with rsp_err=1, tmo_cnt+1 (saturate at FFFF).
//  - RESP: req_ack[id] pulses 1 cycle with rsp_data/rsp_err; rr_ptr <= id+1 (wrap to 0 at NUM_REQ).
//  - Request-to-issue latency from IDLE: 2 cycles (ARB, ISSUE). Back-to-back: 1 idle cycle min.
//  - Requester dropping req_vld after grant: transaction completes, ack still pulses.
//  - ad5522_rst_busy rising during WAIT: transaction continues to done/timeout; no new grant until low.
//  - rst mid-transaction: FSM to IDLE immediately, no ack; pmu_drv reset by same rst.
//  - done pulse in any state other than WAIT is ignored.
//  - busy = (FSM != IDLE).
// CONFIGURATION
//  PMU_CFG_RDBK_EN defined: after each write, FSM inserts RB_ISSUE/RB_WAIT: issues rd_req, compares
//    pmu_cmp_result[21:0] with written data[21:0]; mismatch or timeout sets rsp_err on the write's ack.
//    Write latency grows by one full SPI read.
//  PMU_CFG_RDBK_EN undefined: writes ack on wr_done, no readback states synthesised.
// STRUCTURE
//  - Shared package pmu_pkg: FSM state encoding, PMU_CFG_DW default, CMP compare mask width (22).
//  - One sub-module: pmu_rr_arb (combinational round-robin pick: req vector + ptr -> id, any).
// TESTING
//  1. Single write from req0, data 29'h0123456 -> wr_req pulse 2 cycles after req_vld, wr_data=0123456,
//     req_ack[0] 1 cycle after wr_done, rsp_err=0.
//  2. req0 and req1 both held, 4 writes each -> grants alternate 0,1,0,1...; no requester starved.
//  3. Read from req1, model returns 29'h0400000 -> req_ack[1] with rsp_data=29'h0400000.
//  4. Model withholds done -> ack after TMO_CYC+3 cycles with rsp_err=1, tmo_cnt=1.
//  5. ad5522_rst_busy=1 with req_vld pending -> no wr/rd_req until busy low, then issue in 2 cycles.
//  6. PMU_CFG_RDBK_EN: write 0x000ABCD, readback 0x000ABCC -> rd_req after wr_done, ack with rsp_err=1.

Source files
------------

// File: rtl/pmu_pkg.sv
// Shared definitions for the AD5522 config-path arbiter: FSM encoding, default SPI word width
// and the readback compare width.
package pmu_pkg;

    localparam int PMU_CFG_DW_DEF = 29;
    localparam int CMP_W          = 22;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;
    localparam logic [2:0] ST_RB_ISSUE = 3'd5;
    localparam logic [2:0] ST_RB_WAIT  = 3'd6;

endpackage

// File: rtl/pmu_cfg_arb_if.sv
// Request/done handshake between the config arbiter (master) and pmu_drv (slave).
interface pmu_cfg_arb_if #(
    parameter int DW = 29
) ();

    logic          pmu_cfg_wr_req;
    logic          pmu_cfg_rd_req;
    logic [DW-1:0] pmu_cfg_wr_data;
    logic          pmu_cfg_wr_done;
    logic          pmu_cfg_rd_done;
    logic [DW-1:0] pmu_cmp_result;
    logic          pmu_cmp_result_vld;

    modport master (
        output pmu_cfg_wr_req, pmu_cfg_rd_req, pmu_cfg_wr_data,
        input  pmu_cfg_wr_done, pmu_cfg_rd_done, pmu_cmp_result, pmu_cmp_result_vld
    );

    modport slave (
        input  pmu_cfg_wr_req, pmu_cfg_rd_req, pmu_cfg_wr_data,
        output pmu_cfg_wr_done, pmu_cfg_rd_done, pmu_cmp_result, pmu_cmp_result_vld
    );

endinterface

// File: rtl/pmu_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module pmu_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_id,
    output logic               o_any
);

    always_comb begin
        int w_idx;
        w_idx = 0;
        o_id  = '0;
        o_any = 1'b0;
        // Walk from the farthest offset down so the nearest requester is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_id  = IDW'(w_idx);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmu_cfg_arb.sv
// Round-robin arbiter sharing the AD5522 SPI config path among NUM_REQ requesters.
// Define PMU_CFG_RDBK_EN to read back and compare every write before acknowledging it.
module pmu_cfg_arb
    import pmu_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int PMU_CFG_DW = PMU_CFG_DW_DEF,
    parameter int TMO_CYC    = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_vld,
    input  logic [NUM_REQ-1:0]            i_req_rd,
    input  logic [NUM_REQ*PMU_CFG_DW-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [PMU_CFG_DW-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_busy,
    input  logic                          i_ad5522_rst_busy,
    output logic [15:0]                   o_tmo_cnt,
    pmu_cfg_arb_if.master                 pmu
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TMO_CYC) + 1;

    logic [2:0]            r_state;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_id;
    logic                  r_rd;
    logic [PMU_CFG_DW-1:0] r_data;
    logic [PMU_CFG_DW-1:0] r_rd_data;
    logic [PMU_CFG_DW-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_wr_req;
    logic                  r_rd_req;
    logic [TW-1:0]         r_tmo;
    logic [15:0]           r_tmo_cnt;

    logic [IDW-1:0]        w_id;
    logic                  w_any;
    logic                  w_tmo_hit;
    logic [PMU_CFG_DW-1:0] w_rd_data;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    pmu_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .i_req (i_req_vld),
        .i_ptr (r_ptr),
        .o_id  (w_id),
        .o_any (w_any)
    );

    assign w_tmo_hit = (r_tmo == TW'(TMO_CYC - 1));
    // Read data may arrive in the same cycle as rd_done, so bypass the holding register.
    assign w_rd_data = pmu.pmu_cmp_result_vld ? pmu.pmu_cmp_result : r_rd_data;

    always_ff @(posedge clk) begin
        if (r_state == ST_ISSUE || r_state == ST_RB_ISSUE)
            r_rd_data <= '0;
        else if (pmu.pmu_cmp_result_vld)
            r_rd_data <= pmu.pmu_cmp_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_rd       <= 1'b0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_tmo      <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req_vld && !i_ad5522_rst_busy)
                        r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (w_any && !i_ad5522_rst_busy) begin
                        r_id     <= w_id;
                        r_rd     <= i_req_rd[w_id];
                        r_data   <= i_req_data[int'(w_id)*PMU_CFG_DW +: PMU_CFG_DW];
                        r_wr_req <= ~i_req_rd[w_id];
                        r_rd_req <= i_req_rd[w_id];
                        r_state  <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (r_rd && pmu.pmu_cfg_rd_done) begin
                        r_rsp_data <= w_rd_data;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (!r_rd && pmu.pmu_cfg_wr_done) begin
`ifdef PMU_CFG_RDBK_EN
                        r_rd_req <= 1'b1;
                        r_state  <= ST_RB_ISSUE;
`else
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
`endif
                    end else if (w_tmo_hit) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_tmo_cnt  <= sat_inc16(r_tmo_cnt);
                        r_state    <= ST_RESP;
                    end
                end
`ifdef PMU_CFG_RDBK_EN
                ST_RB_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= ST_RB_WAIT;
                end
                ST_RB_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (pmu.pmu_cfg_rd_done) begin
                        r_rsp_data <= w_rd_data;
                        r_rsp_err  <= (w_rd_data[CMP_W-1:0] != r_data[CMP_W-1:0]);
                        r_state    <= ST_RESP;
                    end else if (w_tmo_hit) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_tmo_cnt  <= sat_inc16(r_tmo_cnt);
                        r_state    <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    r_ptr   <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++)
            o_req_ack[i] = (r_state == ST_RESP) && (r_id == IDW'(i));
    end

    assign o_rsp_data          = r_rsp_data;
    assign o_rsp_err           = r_rsp_err;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_tmo_cnt           = r_tmo_cnt;
    assign pmu.pmu_cfg_wr_req  = r_wr_req;
    assign pmu.pmu_cfg_rd_req  = r_rd_req;
    assign pmu.pmu_cfg_wr_data = r_data;

endmodule
